// File: rtl/uart_rx_periph_pkg.sv
// Shared definitions for the UART receive peripheral: receiver states,
// register addresses and status bit layout.
package uart_rx_periph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam logic [3:0] ADDR_RXDATA = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd2;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_FERR      = 2;
    localparam int STAT_OVR       = 3;

    function automatic logic [15:0] pack_status(input logic ovr, input logic ferr,
                                                 input logic full, input logic not_empty);
        return {12'h000, ovr, ferr, full, not_empty};
    endfunction

endpackage

// File: rtl/uart_rx_periph_if.sv
// Register bus of the UART receive peripheral; the host drives the master side.
interface uart_rx_periph_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        rx_irq;

    modport master (output cs, rd, wr, addr, d_in, input d_out, rx_irq);
    modport slave  (input cs, rd, wr, addr, d_in, output d_out, rx_irq);
endinterface

// File: rtl/uart_rx_periph_fifo.sv
// Synchronous receive FIFO; a push on a full FIFO only lands when a pop
// happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_n;
    logic             full_r;
    logic             empty_r;
    logic             rd_en_s;
    logic             wr_en_s;

    assign rd_en_s = pop && !empty_r;
    assign wr_en_s = push && (!full_r || rd_en_s);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_n = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_n = count_r + CW'(1);
            2'b01:   count_n = count_r - CW'(1);
            default: count_n = count_r;
        endcase
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_n;
            full_r  <= (count_n == CW'(DEPTH));
            empty_r <= (count_n == '0);
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;
endmodule

// File: rtl/uart_rx_periph.sv
// 8N1 UART receiver with 16x oversampling, receive FIFO and a small
// register interface (data pop, status, sticky error clear).
module uart_rx_periph
    import uart_rx_periph_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic             uart_rx,
    uart_rx_periph_if.slave  bus
);
    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       sync_r;
    logic             rx_s;
    logic             rx_prev_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic             tick_s;
    rx_state_t        state_r, state_n;
    logic [3:0]       tick_cnt_r, tick_cnt_n;
    logic [2:0]       bit_cnt_r, bit_cnt_n;
    logic [7:0]       shift_r, shift_n;
    logic             brk_wait_r, brk_wait_n;
    logic             div_clr_s, push_s, ferr_set_s;
    logic             read_s, write_s, pop_s, ovr_set_s, ferr_clr_s, ovr_clr_s;
    logic             ferr_r, ovr_r;
    logic [15:0]      d_out_r;
    logic [7:0]       fifo_dout_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             unused_d_in_s;

    assign rx_s   = sync_r[1];
    assign tick_s = (div_cnt_r == DIV_LAST);

    // Two-flop synchronizer plus previous-value flop for edge detection.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            sync_r    <= {sync_r[0], uart_rx};
            rx_prev_r <= sync_r[1];
        end
    end

    // Oversample divider; realigned to the start edge so ticks sit mid-bit.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || div_clr_s || tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Receiver next-state logic. brk_wait_r holds STOP until the line is high.
    always_comb begin
        state_n    = state_r;
        tick_cnt_n = tick_cnt_r;
        bit_cnt_n  = bit_cnt_r;
        shift_n    = shift_r;
        brk_wait_n = brk_wait_r;
        div_clr_s  = 1'b0;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_prev_r && !rx_s) begin
                    state_n    = ST_START;
                    tick_cnt_n = 4'd0;
                    bit_cnt_n  = 3'd0;
                    brk_wait_n = 1'b0;
                    div_clr_s  = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && tick_cnt_r == 4'd7) begin
                    tick_cnt_n = 4'd0;
                    if (!rx_s) state_n = ST_DATA;
                    else       state_n = ST_IDLE;
                end else if (tick_s) begin
                    tick_cnt_n = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_n = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (tick_s && tick_cnt_r == 4'd15) begin
                    tick_cnt_n = 4'd0;
                    shift_n    = {rx_s, shift_r[7:1]};
                    bit_cnt_n  = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) state_n = ST_STOP;
                    else                   state_n = ST_DATA;
                end else if (tick_s) begin
                    tick_cnt_n = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_n = tick_cnt_r;
                end
            end
            ST_STOP: begin
                if (brk_wait_r) begin
                    if (rx_s) begin
                        state_n    = ST_IDLE;
                        brk_wait_n = 1'b0;
                    end else begin
                        state_n = ST_STOP;
                    end
                end else if (tick_s && tick_cnt_r == 4'd15) begin
                    tick_cnt_n = 4'd0;
                    if (rx_s) begin
                        push_s  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        ferr_set_s = 1'b1;
                        brk_wait_n = 1'b1;
                    end
                end else if (tick_s) begin
                    tick_cnt_n = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_n = tick_cnt_r;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            brk_wait_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            tick_cnt_r <= tick_cnt_n;
            bit_cnt_r  <= bit_cnt_n;
            shift_r    <= shift_n;
            brk_wait_r <= brk_wait_n;
        end
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (sys_clk_i),
        .rst   (sys_rst_i),
        .push  (push_s),
        .pop   (pop_s),
        .din   (shift_r),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign read_s     = bus.cs && bus.rd;
    assign write_s    = bus.cs && bus.wr;
    assign pop_s      = read_s && (bus.addr == ADDR_RXDATA) && !fifo_empty_s;
    assign ovr_set_s  = push_s && fifo_full_s && !pop_s;
    assign ferr_clr_s = write_s && (bus.addr == ADDR_STATUS) && bus.d_in[STAT_FERR];
    assign ovr_clr_s  = write_s && (bus.addr == ADDR_STATUS) && bus.d_in[STAT_OVR];
    assign unused_d_in_s = ^{bus.d_in[15:4], bus.d_in[1:0]};

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ferr_r <= 1'b0;
            ovr_r  <= 1'b0;
        end else begin
            if (ferr_set_s)      ferr_r <= 1'b1;
            else if (ferr_clr_s) ferr_r <= 1'b0;
            if (ovr_set_s)       ovr_r  <= 1'b1;
            else if (ovr_clr_s)  ovr_r  <= 1'b0;
        end
    end

    // Read data register, held until the next read.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            d_out_r <= 16'h0000;
        end else if (read_s) begin
            case (bus.addr)
                ADDR_RXDATA: d_out_r <= fifo_empty_s ? 16'h0000 : {8'h00, fifo_dout_s};
                ADDR_STATUS: d_out_r <= pack_status(ovr_r, ferr_r, fifo_full_s, !fifo_empty_s);
                default:     d_out_r <= 16'h0000;
            endcase
        end
    end

    assign bus.d_out  = d_out_r;
    assign bus.rx_irq = (fifo_count_s != '0);
endmodule

// File: tb/tb_uart_rx_periph.sv
// Scoreboard bench for uart_rx_periph at 640 kHz / 10 kbaud (64 clocks per bit).
module tb_uart_rx_periph;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    always #5 clk = ~clk;

    uart_rx_periph_if bus();

    uart_rx_periph #(.CLK_HZ(640000), .BAUD(10000), .FIFO_DEPTH(4)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .uart_rx   (rx),
        .bus       (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    string       name_q[$];
    logic        rd_pend = 1'b0;
    logic [15:0] mon_exp;
    string       mon_name;

    // Marks the cycle in which a read result becomes visible.
    always @(posedge clk) rd_pend <= bus.cs & bus.rd;

    // Monitor: compare every read result with the head of the scoreboard.
    always @(negedge clk) begin
        if (rd_pend) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read got=%h expected=none", bus.d_out);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (bus.d_out !== mon_exp) begin
                    n_err++;
                    $display("FAIL %s got=%h expected=%h", mon_name, bus.d_out, mon_exp);
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [15:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.wr = 1'b0; bus.d_in = 16'h0000;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        rx = 1'b0;
        hold(64);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(64);
        end
        rx = stop;
        hold(64);
        rx = 1'b1;
        hold(4);
    endtask

    initial begin
        bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        bus.addr = 4'd0; bus.d_in = 16'h0000;
        hold(3);
        check("reset_d_out", bus.d_out, 16'h0000);
        check("reset_irq", {15'd0, bus.rx_irq}, 16'h0000);
        rst = 1'b0;
        hold(4);
        bus_read(4'd2, 16'h0000, "reset_status");

        // Single good frame
        send_byte(8'hA5, 1'b1);
        check("irq_after_a5", {15'd0, bus.rx_irq}, 16'h0001);
        bus_read(4'd2, 16'h0001, "status_a5");
        bus_read(4'd0, 16'h00A5, "data_a5");
        hold(2);
        check("irq_after_pop", {15'd0, bus.rx_irq}, 16'h0000);
        bus_read(4'd2, 16'h0000, "status_after_pop");
        bus_read(4'd0, 16'h0000, "read_empty");

        // Start-bit glitch
        rx = 1'b0;
        hold(20);
        rx = 1'b1;
        hold(80);
        bus_read(4'd2, 16'h0000, "status_glitch");
        check("irq_glitch", {15'd0, bus.rx_irq}, 16'h0000);

        // Framing error and clear
        send_byte(8'h3C, 1'b0);
        bus_read(4'd2, 16'h0004, "status_ferr");
        bus_write(4'd2, 16'h0004);
        bus_read(4'd2, 16'h0000, "status_ferr_clr");

        // Overrun
        for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b1);
        bus_read(4'd2, 16'h000B, "status_ovr");
        bus_read(4'd0, 16'h0001, "ovr_rd1");
        bus_read(4'd0, 16'h0002, "ovr_rd2");
        bus_read(4'd0, 16'h0003, "ovr_rd3");
        bus_read(4'd0, 16'h0004, "ovr_rd4");
        bus_read(4'd0, 16'h0000, "ovr_rd5");
        bus_read(4'd2, 16'h0008, "status_ovr_only");
        bus_write(4'd2, 16'h0008);
        bus_read(4'd2, 16'h0000, "status_ovr_clr");

        // Reset during the 4th data bit of 0xFF
        rx = 1'b0;
        hold(64);
        rx = 1'b1;
        hold(3 * 64 + 32);
        rst = 1'b1;
        hold(2);
        check("midrst_d_out", bus.d_out, 16'h0000);
        check("midrst_irq", {15'd0, bus.rx_irq}, 16'h0000);
        rst = 1'b0;
        hold(5 * 64);
        bus_read(4'd2, 16'h0000, "status_after_rst");
        send_byte(8'h5A, 1'b1);
        bus_read(4'd0, 16'h005A, "data_5a");
        bus_read(4'd2, 16'h0000, "status_5a_done");

        // Pop coinciding with a push into a full FIFO
        for (int k = 0; k < 4; k++) send_byte(8'h11 + 8'(k), 1'b1);
        bus_read(4'd2, 16'h0003, "status_full");
        fork
            send_byte(8'h77, 1'b1);
            begin
                repeat (610) @(posedge clk);
                bus_read(4'd0, 16'h0011, "coinc_pop");
            end
        join
        bus_read(4'd2, 16'h0003, "status_coinc_no_ovr");
        bus_read(4'd0, 16'h0012, "coinc_rd1");
        bus_read(4'd0, 16'h0013, "coinc_rd2");
        bus_read(4'd0, 16'h0014, "coinc_rd3");
        bus_read(4'd0, 16'h0077, "coinc_rd4");
        bus_read(4'd2, 16'h0000, "status_final");

        hold(5);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_periph.md
UART_RX_PERIPH -- requirements
Module: uart_rx_periph

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two).
REQ-004 sys_clk_i  input  1  system clock; everything is on the rising edge.
REQ-005 sys_rst_i  input  1  reset, synchronous and active-high.
REQ-006 uart_rx  input  1  asynchronous serial line; idles high; 8N1 format.
REQ-007 cs  input  1  peripheral chip select.
REQ-008 rd  input  1  read strobe, qualified by cs.
REQ-009 wr  input  1  write strobe, qualified by cs.
REQ-010 addr  input  4  register address.
REQ-011 d_in  input  16  write data.
REQ-012 d_out  output  16  registered read data.
REQ-013 rx_irq  output  1  high while the FIFO is non-empty.

Function
REQ-014 SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-015 SHALL generate a 16x oversample tick every DIV = CLK_HZ/(BAUD*16) clocks (integer division, minimum 1).
- The tick counter free-runs.
- The tick counter restarts at 0 on start-bit detection.
REQ-016 SHALL implement the states IDLE, START, DATA and STOP.
REQ-017 IDLE: a synchronized 1->0 transition SHALL move the block to START.
REQ-018 START: after 8 ticks, the line is sampled.
- Low: go to DATA.
- High: treat as a glitch and return to IDLE; nothing is recorded.
REQ-019 DATA: SHALL sample every 16 ticks and shift the bits in LSB first, for exactly 8 bits, then go to STOP.
REQ-020 STOP: SHALL sample after 16 ticks.
- High: push the byte to the FIFO.
- Low: set FERR sticky and discard the byte.
REQ-021 After STOP, SHALL return to IDLE only once the line is high, so a held-low break never produces a new frame.
REQ-022 Push into a full FIFO SHALL drop the new byte and set OVR sticky; the FIFO contents are unchanged.
REQ-023 Push and pop in the same cycle on a full FIFO SHALL both take effect, with no overrun.
REQ-024 Register map:
- addr 0 read: {8'h00, FIFO head}. Pops the head when the FIFO is non-empty. Returns 16'h0000 with no pop when empty.
- addr 2 read: {12'h000, OVR, FERR, full, not_empty}. No side effects.
- addr 2 write: d_in[2]=1 clears FERR; d_in[3]=1 clears OVR.
- Other addresses: reads return 0; writes are ignored.
REQ-025 d_out SHALL be valid on the clock after cs&rd and SHALL hold until the next read.
REQ-026 A flag set event and a clear write in the same cycle SHALL leave the flag set.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
- full/empty is resolved by an occupancy count of width log2(FIFO_DEPTH)+1.

Reset
REQ-028 On sys_rst_i, in the same edge:
- state = IDLE;
- FIFO empty, pointers 0;
- FERR = OVR = 0;
- d_out = 16'h0000;
- rx_irq = 0;
- synchronizer flops = 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame. No partial byte is pushed.

Structure
REQ-030 The shared package SHALL hold:
- the state encoding (IDLE/START/DATA/STOP);
- register address constants ADDR_RXDATA = 0 and ADDR_STATUS = 2;
- status bit positions.
REQ-031 The FIFO SHALL be a separate sub-module, uart_rx_fifo: synchronous, with push, pop, dout, full, empty and count.
REQ-032 Divisor, synchronizer and FSM SHALL stay in uart_rx_periph.

Verification (CLK_HZ=640000, BAUD=10000 -> DIV=4, 64 clocks per bit)
REQ-033 Send byte 0xA5 with a valid stop -> not_empty=1 and rx_irq=1 after the stop sample; read addr 0 -> d_out=16'h00A5 next clock; the FIFO is then empty and rx_irq=0.
REQ-034 Low pulse of 20 clocks on an idle line -> no byte; state back to IDLE; status = 16'h0000.
REQ-035 Send 0x3C with the stop bit driven low -> status bit2=1 and FIFO empty; write addr 2 with 16'h0004 -> status = 16'h0000.
REQ-036 Send bytes 0x01..0x05 without reading -> status = 16'h000B (OVR, full, not_empty); reads return 0x01..0x04; a fifth read returns 16'h0000.
REQ-037 Assert sys_rst_i during the 4th data bit of 0xFF -> after release, FIFO empty and no byte appears; the next frame 0x5A is received correctly.
REQ-038 FIFO full, and a read of addr 0 coincides with the push of 0x77 -> OVR stays 0; the last of 4 subsequent reads returns 0x77.
